note_sequencer: RTL and testbench

- Synthesizable melody sequencer. Drives the 8-bit one-hot note bus that feeds the piano tone generator (DO..DO1 counter-period selector).
- Fetches note/duration entries from a small song ROM and times each note with beat and gap counters.
- Arbitrates the note bus between manual switch input (SW[7:0]) and song playback.
- Replaces delay-based melody stepping with a real FSM clocked from CLOCK_27.

---
 rtl/piano_pkg.sv | 30 +++
 rtl/note_sequencer_if.sv | 14 +
 rtl/song_rom.sv | 38 +++
 rtl/note_sequencer.sv | 107 ++++++++++
 tb/tb_note_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: note codes, duration encoding, song base addresses and note-bus helpers
package piano_pkg;
    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_SI   = 4'd7;
    localparam logic [3:0] NOTE_DO1  = 4'd8;
    localparam logic [3:0] NOTE_END  = 4'd15;

    typedef enum logic [1:0] {DUR_1, DUR_2, DUR_3, DUR_4} dur_t;

    localparam logic [5:0] SONG0_BASE = 6'd0;
    localparam logic [5:0] SONG1_BASE = 6'd32;

    function automatic logic [7:0] code_to_onehot(input logic [3:0] code);
        return (code >= NOTE_DO && code <= NOTE_DO1) ? 8'(8'd1 << (code - NOTE_DO)) : 8'd0;
    endfunction

    function automatic logic [5:0] song_base(input logic sel);
        return sel ? SONG1_BASE : SONG0_BASE;
    endfunction

    function automatic logic [5:0] rom_entry(input logic [3:0] code, input dur_t dur);
        return {code, dur};
    endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control/status bundle between a host (master) and the sequencer (slave)
interface note_sequencer_if #(parameter int ADDR_W = 6);
    logic              start;
    logic              stop;
    logic              song_sel;
    logic [7:0]        manual_notes;
    logic [7:0]        notes;
    logic              playing;
    logic              done;
    logic [ADDR_W-1:0] step;

    modport master(output start, stop, song_sel, manual_notes, input notes, playing, done, step);
    modport slave(input start, stop, song_sel, manual_notes, output notes, playing, done, step);
endinterface

// File: rtl/song_rom.sv
// song_rom: registered case-ROM holding Brilha Brilha Estrelinha (base 0) and Jingle Bells (base 32)
module song_rom
    import piano_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              CLOCK_27,
    input  logic [ADDR_W-1:0] addr,
    output logic [5:0]        data
);
    logic [5:0] w_entry;
    logic [5:0] r_data;

    always_comb begin
        case (int'(addr))
            0, 1:                   w_entry = rom_entry(NOTE_DO, DUR_1);
            2, 3:                   w_entry = rom_entry(NOTE_SOL, DUR_1);
            4, 5:                   w_entry = rom_entry(NOTE_LA, DUR_1);
            6:                      w_entry = rom_entry(NOTE_SOL, DUR_2);
            7, 8:                   w_entry = rom_entry(NOTE_FA, DUR_1);
            9, 10:                  w_entry = rom_entry(NOTE_MI, DUR_1);
            11, 12:                 w_entry = rom_entry(NOTE_RE, DUR_1);
            13:                     w_entry = rom_entry(NOTE_DO, DUR_2);
            32, 33, 35, 36, 38:     w_entry = rom_entry(NOTE_MI, DUR_1);
            34, 37:                 w_entry = rom_entry(NOTE_MI, DUR_2);
            39:                     w_entry = rom_entry(NOTE_SOL, DUR_1);
            40:                     w_entry = rom_entry(NOTE_DO, DUR_1);
            41:                     w_entry = rom_entry(NOTE_RE, DUR_1);
            42:                     w_entry = rom_entry(NOTE_MI, DUR_4);
            43:                     w_entry = rom_entry(NOTE_REST, DUR_1);
            default:                w_entry = rom_entry(NOTE_END, DUR_1);
        endcase
    end

    always_ff @(posedge CLOCK_27) r_data <= w_entry;

    assign data = r_data;
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: song-ROM melody player arbitrating the one-hot note bus with manual switches.
// Define NOTE_SEQUENCER_LOOP_EN to repeat the selected song until stop instead of ending at END.
module note_sequencer
    import piano_pkg::*;
#(
    parameter int BEAT_CYCLES = 13500000,
    parameter int GAP_CYCLES  = 1350000,
    parameter int ADDR_W      = 6,
    parameter int CNT_W       = 26
) (
    input  logic             CLOCK_27,
    input  logic             Reset,
    note_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_NOTE   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        r_state;
    logic [7:0]        r_notes;
    logic              r_done;
    logic              r_song;
    logic [ADDR_W-1:0] r_step;
    logic [CNT_W-1:0]  r_cnt;
    logic [5:0]        w_rom;
    logic [3:0]        w_code;
    logic [1:0]        w_dur;
    logic              w_end;
    logic              w_go;
    logic [CNT_W-1:0]  w_load;

    song_rom #(.ADDR_W(ADDR_W)) u_rom (.CLOCK_27(CLOCK_27), .addr(r_step), .data(w_rom));

    assign w_code = w_rom[5:2];
    assign w_dur  = w_rom[1:0];
    // the last ROM slot ends the song rather than wrapping into the other melody
    assign w_end  = (w_code == NOTE_END) || (r_step == '1);
    assign w_go   = bus.start && !bus.stop;
    assign w_load = CNT_W'((32'(w_dur) + 32'd1) * 32'(BEAT_CYCLES) - 32'(GAP_CYCLES) - 32'd1);

    always_ff @(posedge CLOCK_27 or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_notes <= 8'd0;
            r_done  <= 1'b0;
            r_song  <= 1'b0;
            r_step  <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && bus.stop) begin
                r_state <= S_IDLE;
                r_notes <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_notes <= w_go ? 8'd0 : bus.manual_notes;
                        if (w_go) begin
                            r_song  <= bus.song_sel;
                            r_step  <= ADDR_W'(song_base(bus.song_sel));
                            r_state <= S_FETCH;
                        end
                    end
                    S_FETCH: r_state <= S_DECODE;
                    S_DECODE: begin
                        if (w_end) begin
                            r_done <= 1'b1;
`ifdef NOTE_SEQUENCER_LOOP_EN
                            r_step  <= ADDR_W'(song_base(r_song));
                            r_state <= S_FETCH;
`else
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_cnt   <= w_load;
                            r_notes <= code_to_onehot(w_code);
                            r_state <= S_NOTE;
                        end
                    end
                    S_NOTE: begin
                        r_cnt   <= (r_cnt == '0) ? CNT_W'(GAP_CYCLES - 1) : r_cnt - 1'b1;
                        r_notes <= (r_cnt == '0) ? 8'd0 : r_notes;
                        r_state <= (r_cnt == '0) ? S_GAP : S_NOTE;
                    end
                    S_GAP: begin
                        r_cnt   <= (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
                        r_step  <= (r_cnt == '0) ? r_step + 1'b1 : r_step;
                        r_state <= (r_cnt == '0) ? S_FETCH : S_GAP;
                    end
                    S_DONE: begin
                        r_notes <= 8'd0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.notes   = r_notes;
    assign bus.playing = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.step    = r_step;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: randomized bench comparing note_sequencer against a per-cycle song timeline model
module tb_note_sequencer;
    localparam int B = 8;
    localparam int G = 2;

    typedef struct packed {
        logic [7:0] n;
        logic       p;
        logic       d;
        logic [5:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] rom [64];
    exp_t eq[$];
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    note_sequencer_if #(.ADDR_W(6)) bus();

    note_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .ADDR_W(6), .CNT_W(8)) dut (
        .CLOCK_27(clk),
        .Reset(rst_n),
        .bus(bus)
    );

    function automatic exp_t mk(input logic [7:0] n, input logic p, input logic d, input int s);
        return {n, p, d, 6'(s)};
    endfunction

    task automatic load_rom();
        int c0[14] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1};
        int d0[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        int c1[12] = '{3, 3, 3, 3, 3, 3, 3, 5, 1, 2, 3, 0};
        int d1[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 3, 0};
        for (int i = 0; i < 64; i++) rom[i] = {4'd15, 2'd0};
        for (int i = 0; i < 14; i++) rom[i] = {4'(c0[i]), 2'(d0[i])};
        for (int i = 0; i < 12; i++) rom[32 + i] = {4'(c1[i]), 2'(d1[i])};
    endtask

    // expected outputs for each cycle after the start edge, derived from entry timing rules
    task automatic build(input bit sel);
        int s, base, code, dur, reps;
        bit pend;
        logic [7:0] oh;
        eq.delete();
        base = sel ? 32 : 0;
        s = base;
        reps = 0;
        pend = 0;
        for (int guard = 0; guard < 100; guard++) begin
            code = int'(rom[s][5:2]);
            dur = int'(rom[s][1:0]);
            eq.push_back(mk(8'h00, 1, pend, s));
            pend = 0;
            eq.push_back(mk(8'h00, 1, 0, s));
            if (code == 15 || s == 63) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                pend = 1;
                s = base;
                reps++;
`else
                eq.push_back(mk(8'h00, 1, 1, s));
                break;
`endif
            end else begin
                oh = (code >= 1 && code <= 8) ? 8'(1 << (code - 1)) : 8'h00;
                repeat ((dur + 1) * B - G) eq.push_back(mk(oh, 1, 0, s));
                repeat (G) eq.push_back(mk(8'h00, 1, 0, s));
                s++;
                if (reps == 1) break;
            end
        end
    endtask

    task automatic kick(input bit sel);
        bus.song_sel = sel;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic play(input string tag);
        exp_t got;
        for (int i = 0; i < eq.size(); i++) begin
            bus.start = 1'b0;
            got = {bus.notes, bus.playing, bus.done, bus.step};
            checks++;
            if (got !== eq[i]) begin
                fails++;
                $display("FAIL %s cycle %0d: notes/playing/done/step got %h/%b/%b/%0d want %h/%b/%b/%0d",
                         tag, i, got.n, got.p, got.d, got.s, eq[i].n, eq[i].p, eq[i].d, eq[i].s);
            end
            bus.manual_notes = 8'($urandom);
            if (eq[i].p && $urandom_range(7, 0) == 0) begin
                bus.song_sel = 1'($urandom);
                bus.start = 1'b1;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic finish_song(input string tag);
        logic [7:0] m;
`ifdef NOTE_SEQUENCER_LOOP_EN
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        checks++;
        if (bus.playing !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL %s loop_stop: playing/done got %b/%b want 0/0", tag, bus.playing, bus.done);
        end
`else
        checks++;
        if (bus.playing !== 1'b0 || bus.done !== 1'b0 || bus.notes !== 8'h00) begin
            fails++;
            $display("FAIL %s end_idle: playing/done/notes got %b/%b/%h want 0/0/00",
                     tag, bus.playing, bus.done, bus.notes);
        end
`endif
        m = 8'd1 << $urandom_range(7, 0);
        bus.manual_notes = m;
        @(negedge clk);
        checks++;
        if (bus.notes !== m) begin
            fails++;
            $display("FAIL %s manual_after: notes got %h want %h", tag, bus.notes, m);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.song_sel = 1'b0;
        bus.manual_notes = 8'h5a;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.notes, bus.playing, bus.done, bus.step} !== 16'h0) begin
            fails++;
            $display("FAIL reset_held: notes/playing/done/step got %h/%b/%b/%0d want 0",
                     bus.notes, bus.playing, bus.done, bus.step);
        end
        bus.manual_notes = 8'h00;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.notes !== 8'h00) begin fails++; $display("FAIL reset_notes: got %h want 00", bus.notes); end
        checks++;
        if (bus.playing !== 1'b0) begin fails++; $display("FAIL reset_playing: got %b want 0", bus.playing); end
        checks++;
        if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++;
        if (bus.step !== 6'd0) begin fails++; $display("FAIL reset_step: got %0d want 0", bus.step); end
    endtask

    task automatic test_manual();
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m = (i == 0) ? 8'b0001_0000 : 8'd1 << $urandom_range(7, 0);
            bus.manual_notes = m;
            bus.stop = 1'($urandom);
            @(negedge clk);
            checks++;
            if (bus.notes !== m || bus.playing !== 1'b0) begin
                fails++;
                $display("FAIL manual_pass %0d: notes/playing got %h/%b want %h/0", i, bus.notes, bus.playing, m);
            end
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_start_stop();
        bus.start = 1'b1;
        bus.stop = 1'b1;
        bus.song_sel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop = 1'b0;
        checks++;
        if (bus.playing !== 1'b0 || bus.step !== 6'd0) begin
            fails++;
            $display("FAIL start_stop_same: playing/step got %b/%0d want 0/0", bus.playing, bus.step);
        end
    endtask

    task automatic test_song(input bit sel);
        build(sel);
        kick(sel);
        play(sel ? "song1" : "song0");
        finish_song(sel ? "song1" : "song0");
    endtask

    task automatic test_stop();
        logic [7:0] m;
        bus.manual_notes = 8'b0001_0000;
        kick(0);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.notes !== 8'h01 || bus.playing !== 1'b1) begin
            fails++;
            $display("FAIL stop_pre: notes/playing got %h/%b want 01/1", bus.notes, bus.playing);
        end
        m = 8'd1 << $urandom_range(7, 0);
        bus.manual_notes = m;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        checks++;
        if (bus.playing !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL stop_next: playing/done got %b/%b want 0/0", bus.playing, bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.notes !== m) begin
            fails++;
            $display("FAIL stop_manual: notes got %h want %h", bus.notes, m);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.playing !== 1'b0) begin
                fails++;
                $display("FAIL stop_quiet %0d: done/playing got %b/%b want 0/0", i, bus.done, bus.playing);
            end
        end
    endtask

    task automatic test_reset_mid();
        kick(1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.notes !== 8'h00 || bus.step !== 6'd0 || bus.playing !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: notes/step/playing/done got %h/%0d/%b/%b want 00/0/0/0",
                     bus.notes, bus.step, bus.playing, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build(1);
        kick(1);
        play("after_reset");
        finish_song("after_reset");
    endtask

    initial begin
        load_rom();
        test_reset();
        test_manual();
        test_start_stop();
        test_song(0);
        test_song(1);
        test_stop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
